// File: rtl/forthsuper_pkg.sv
// rtl/forthsuper_pkg.sv - shared types and constants for the inner interpreter sequencer
package forthsuper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DISP  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } seq_sts;

  localparam logic [7:0] OP_EXIT = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// rtl/seq_wdog.sv - per-opcode dispatch watchdog, used by inner_seq when INNER_SEQ_WDOG_EN is defined
module seq_wdog #(
  parameter int TMO = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds at LAST so a stuck run never wraps back past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (run_i && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/inner_seq.sv
// rtl/inner_seq.sv - thread sequencer feeding opcodes to inner; watchdog built in with INNER_SEQ_WDOG_EN
module inner_seq
  import forthsuper_pkg::*;
#(
  parameter int DSZ = 8,
  parameter int ASZ = 17,
  parameter int TMO = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ASZ-1:0] pfa,
  input  logic           abort,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_re,
  input  logic [DSZ-1:0] mem_rd,
  output logic           ex_en,
  output logic [ASZ-1:0] ex_pfa,
  output logic [DSZ-1:0] ex_op,
  input  logic           ex_bsy,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [15:0]    nops
);

  seq_sts         st_q, st_d;
  logic [ASZ-1:0] ip_q, ip_d;
  logic [DSZ-1:0] op_q, op_d;
  logic [15:0]    nops_q, nops_d;
  logic           err_q, err_d;
  logic           disp_seen_q;
  logic           wdog_exp;
  logic           disp_ok;
  logic           tmo_hit;

`ifdef INNER_SEQ_WDOG_EN
  seq_wdog #(.TMO(TMO)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (st_q != ST_DISP),
    .run_i    (st_q == ST_DISP),
    .expire_o (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  // inner's bsy is combinational on ex_en, so the first DISP cycle never counts as done.
  assign disp_ok = disp_seen_q && !ex_bsy;
  assign tmo_hit = wdog_exp && ex_bsy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (abort) begin
      st_d = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE:  if (start) st_d = ST_FETCH;
        ST_FETCH: st_d = ST_WAIT;
        ST_WAIT:  st_d = (mem_rd == DSZ'(OP_EXIT)) ? ST_DONE : ST_DISP;
        ST_DISP: begin
          if (tmo_hit)      st_d = ST_DONE;
          else if (disp_ok) st_d = ST_NEXT;
        end
        ST_NEXT:  st_d = ST_FETCH;
        ST_DONE:  st_d = ST_IDLE;
        default:  st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_re = (st_q == ST_FETCH);
    mem_a  = mem_re ? ip_q : '0;
    ex_en  = (st_q == ST_DISP);
    ex_pfa = ip_q;
    ex_op  = op_q;
    busy   = (st_q != ST_IDLE);
    done   = (st_q == ST_DONE);
    nops   = nops_q;
    err    = err_q;
  end

  always_comb begin
    ip_d   = ip_q;
    op_d   = op_q;
    nops_d = nops_q;
    err_d  = err_q;
    if (!abort) begin
      case (st_q)
        ST_IDLE: if (start) begin
          ip_d   = pfa;
          nops_d = '0;
          err_d  = 1'b0;
        end
        ST_WAIT: op_d = mem_rd;
        ST_DISP: begin
          if (tmo_hit)      err_d  = 1'b1;
          else if (disp_ok) nops_d = sat_inc16(nops_q);
        end
        ST_NEXT: ip_d = ip_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q        <= '0;
      op_q        <= '0;
      nops_q      <= '0;
      err_q       <= 1'b0;
      disp_seen_q <= 1'b0;
    end else begin
      ip_q        <= ip_d;
      op_q        <= op_d;
      nops_q      <= nops_d;
      err_q       <= err_d;
      disp_seen_q <= (st_q == ST_DISP);
    end
  end

endmodule

// File: tb/tb_inner_seq.sv
// tb/tb_inner_seq.sv - scoreboard bench for inner_seq with memory and mock inner models
module tb_inner_seq;

  localparam int DSZ = 8;
  localparam int ASZ = 17;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [ASZ-1:0] pfa = '0;
  logic [ASZ-1:0] mem_a, ex_pfa;
  logic           mem_re, ex_en, ex_bsy, busy, done, err;
  logic [DSZ-1:0] mem_rd, ex_op;
  logic [15:0]    nops;

  logic [7:0] mem [0:(1<<ASZ)-1];
  int         cnt_en;
  logic       hold_bsy = 1'b0;
  int         cyc = 0;

  typedef struct packed {
    logic [7:0]     op;
    logic [ASZ-1:0] pfa;
  } disp_t;

  disp_t          sb[$];
  disp_t          exp_d;
  int             n_chk = 0, n_fail = 0;
  int             done_cnt = 0, disp_cnt = 0, fetch_cnt = 0;
  int             done_cyc = 0, disp_cyc = 0, fetch_cyc = 0;
  logic           en_prev = 1'b0;
  logic [ASZ-1:0] last_fetch_a = '0;

  always #5 clk = ~clk;

  inner_seq #(.DSZ(DSZ), .ASZ(ASZ), .TMO(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .pfa    (pfa),
    .abort  (abort),
    .mem_a  (mem_a),
    .mem_re (mem_re),
    .mem_rd (mem_rd),
    .ex_en  (ex_en),
    .ex_pfa (ex_pfa),
    .ex_op  (ex_op),
    .ex_bsy (ex_bsy),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .nops   (nops)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_re) mem_rd <= mem[mem_a];

  // Mock inner: busy for the first two enabled cycles, or forever while hold_bsy is set.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_en <= 0;
    else        cnt_en <= ex_en ? cnt_en + 1 : 0;
  assign ex_bsy = ex_en && (hold_bsy || cnt_en < 2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re) begin
        chk("re_en_exclusive", {31'd0, ex_en}, 32'd0);
        fetch_cnt++;
        fetch_cyc = cyc;
        last_fetch_a = mem_a;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ex_en && !en_prev) begin
        disp_cnt++;
        disp_cyc = cyc;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_d = sb.pop_front();
          chk("ex_op", {24'd0, ex_op}, {24'd0, exp_d.op});
          chk("ex_pfa", {15'd0, ex_pfa}, {15'd0, exp_d.pfa});
        end
      end
    end
    en_prev = ex_en;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [ASZ-1:0] a);
    sb.push_back('{op: op, pfa: a});
  endtask

  task automatic kick(input logic [ASZ-1:0] a);
    pfa   = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
    chk(tag, done_cnt - d0, 32'd1);
  endtask

  task automatic chk_all_zero();
    chk("z_busy",   {31'd0, busy},   32'd0);
    chk("z_done",   {31'd0, done},   32'd0);
    chk("z_err",    {31'd0, err},    32'd0);
    chk("z_mem_re", {31'd0, mem_re}, 32'd0);
    chk("z_ex_en",  {31'd0, ex_en},  32'd0);
    chk("z_mem_a",  {15'd0, mem_a},  32'd0);
    chk("z_ex_pfa", {15'd0, ex_pfa}, 32'd0);
    chk("z_ex_op",  {24'd0, ex_op},  32'd0);
    chk("z_nops",   {16'd0, nops},   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0, e0, f0;
    foreach (mem[i]) mem[i] = 8'h00;
    tick(2);
    chk_all_zero();
    rst_n = 1'b1;
    tick();

    // 1: two opcodes then EXIT
    mem[100] = 8'h05; mem[101] = 8'h07; mem[102] = 8'h00;
    push(8'h05, 17'd100); push(8'h07, 17'd101);
    d0 = done_cnt;
    kick(17'd100);
    wait_done(d0, "t1_done");
    chk("t1_nops", {16'd0, nops}, 32'd2);
    chk("t1_err", {31'd0, err}, 32'd0);
    tick(3);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t1_done_once", done_cnt - d0, 32'd1);
    chk("t1_sb_drained", sb.size(), 32'd0);

    // 2: immediate EXIT
    d0 = done_cnt; e0 = disp_cnt;
    kick(17'd150);
    wait_done(d0, "t2_done");
    chk("t2_latency", done_cyc - fetch_cyc, 32'd2);
    chk("t2_no_disp", disp_cnt - e0, 32'd0);
    chk("t2_nops", {16'd0, nops}, 32'd0);
    tick(2);

    // 3: ip wraps from the top of the address space
    mem[17'h1FFFF] = 8'h09; mem[0] = 8'h00;
    push(8'h09, 17'h1FFFF);
    d0 = done_cnt;
    kick(17'h1FFFF);
    wait_done(d0, "t3_done");
    chk("t3_wrap_a", {15'd0, last_fetch_a}, 32'd0);
    chk("t3_nops", {16'd0, nops}, 32'd1);
    tick(2);

    // 4: abort during dispatch of the second opcode
    mem[200] = 8'h11; mem[201] = 8'h22; mem[202] = 8'h33; mem[203] = 8'h00;
    push(8'h11, 17'd200); push(8'h22, 17'd201);
    d0 = done_cnt; e0 = disp_cnt;
    kick(17'd200);
    for (int i = 0; i < 300 && disp_cnt < e0 + 2; i++) tick();
    chk("t4_reach_disp2", disp_cnt - e0, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_en_drop", {31'd0, ex_en}, 32'd0);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    tick(5);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_nops_hold", {16'd0, nops}, 32'd1);
    push(8'h05, 17'd100); push(8'h07, 17'd101);
    d0 = done_cnt;
    kick(17'd100);
    wait_done(d0, "t4_restart_done");
    chk("t4_restart_nops", {16'd0, nops}, 32'd2);
    tick(2);

`ifdef INNER_SEQ_WDOG_EN
    // 5: inner never finishes, watchdog ends the thread
    mem[400] = 8'h66; mem[401] = 8'h00;
    push(8'h66, 17'd400);
    hold_bsy = 1'b1;
    d0 = done_cnt;
    kick(17'd400);
    wait_done(d0, "t5_done");
    chk("t5_tmo_cycles", done_cyc - disp_cyc, 32'd8);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_nops", {16'd0, nops}, 32'd0);
    chk("t5_en_low", {31'd0, ex_en}, 32'd0);
    hold_bsy = 1'b0;
    tick(2);
    push(8'h05, 17'd100); push(8'h07, 17'd101);
    d0 = done_cnt;
    kick(17'd100);
    chk("t5_err_clr", {31'd0, err}, 32'd0);
    wait_done(d0, "t5_after_done");
    chk("t5_after_nops", {16'd0, nops}, 32'd2);
    tick(2);
`endif

    // 6: reset in WAIT, then start while busy is ignored
    f0 = fetch_cnt;
    kick(17'd100);
    for (int i = 0; i < 20 && fetch_cnt == f0; i++) tick();
    chk("t6_fetch_seen", {31'd0, fetch_cnt != f0}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero();
    tick(2);
    rst_n = 1'b1;
    tick();
    mem[300] = 8'h44; mem[301] = 8'h00;
    push(8'h44, 17'd300);
    d0 = done_cnt; e0 = disp_cnt;
    kick(17'd300);
    for (int i = 0; i < 50 && disp_cnt == e0; i++) tick();
    chk("t6_in_disp", disp_cnt - e0, 32'd1);
    kick(17'd100);
    wait_done(d0, "t6_done");
    chk("t6_nops", {16'd0, nops}, 32'd1);
    tick(4);
    chk("t6_no_restart", {31'd0, busy}, 32'd0);
    chk("t6_sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
